bus_resp_mux_dp: RTL and testbench

//  Registered data-phase response multiplexer for the bus interconnect, between slave

---
 rtl/bus_resp_mux_dp_pkg.sv | 23 ++
 rtl/bus_resp_mux_dp_if.sv | 29 ++
 rtl/bus_resp_mux_dp_timeout.sv | 31 +++
 rtl/bus_resp_mux_dp.sv | 125 ++++++++++++
 tb/tb_bus_resp_mux_dp.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_resp_mux_dp_pkg.sv
// Shared types and constants for the data-phase response multiplexer.
package bus_mux_pkg;

  // Data-phase state of the multiplexer.
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR1,
    ERR2
  } mux_state_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Slot 0 is the internal default slave that answers unmapped accesses.
  localparam int unsigned DEFAULT_SLAVE_IDX = 0;

  // True when a decoder index addresses one of the external slaves 1..num_slave.
  function automatic logic sel_is_mapped(input int unsigned sel, input int unsigned num_slave);
    return (sel != DEFAULT_SLAVE_IDX) && (sel <= num_slave);
  endfunction

endpackage

// File: rtl/bus_resp_mux_dp_if.sv
// Bus-side signals of the response multiplexer. The slave modport is the
// multiplexer's view; the master modport is the view of whoever drives the
// decoder select and the slave responses (interconnect or testbench).
interface bus_resp_mux_dp_if #(
  parameter int DWidth     = 32,
  parameter int NumofSlave = 4
);
  localparam int MuxWidth = $clog2(NumofSlave + 1);

  logic [MuxWidth-1:0]               mux_sel_i;
  logic                              trans_i;
  logic [NumofSlave:0][DWidth-1:0]   rdata_i;
  logic [NumofSlave:0]               resp_i;
  logic [NumofSlave:0]               readyout_i;
  logic [MuxWidth-1:0]               dp_sel_o;
  logic [DWidth-1:0]                 rdata_o;
  logic                              resp_o;
  logic                              ready_o;

  modport slave (
    input  mux_sel_i, trans_i, rdata_i, resp_i, readyout_i,
    output dp_sel_o, rdata_o, resp_o, ready_o
  );

  modport master (
    output mux_sel_i, trans_i, rdata_i, resp_i, readyout_i,
    input  dp_sel_o, rdata_o, resp_o, ready_o
  );
endinterface

// File: rtl/bus_resp_mux_dp_timeout.sv
// Wait-state counter for the response multiplexer: counts stalled cycles of
// the current transfer and flags the last allowed stall cycle.
module bus_mux_timeout #(
  parameter int TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,    // a new transfer enters its data phase
  input  logic stall_i,    // data phase active and the slave is not ready
  output logic expired_o   // this stall cycle is the last one tolerated
);
  localparam int                  CntWidth  = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] count;

  assign expired_o = stall_i && (count == LastCount);

  // Count stall cycles; hold once expired so the value never wraps.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (stall_i && !expired_o) begin
      count <= count + CntWidth'(1);
    end
  end
endmodule

// File: rtl/bus_resp_mux_dp.sv
// Registered data-phase response multiplexer. Captures the decoder select on
// an accepted address phase and routes the addressed slave's rdata/resp/ready
// to the master during the data phase. Unmapped accesses receive a two-cycle
// ERROR from the internal default slave in slot 0.
// Optional feature macro: BUS_MUX_TIMEOUT_EN (wait-state limit forcing ERROR).
module bus_resp_mux_dp
  import bus_mux_pkg::*;
#(
  parameter int DWidth        = 32,
  parameter int NumofSlave    = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bus_resp_mux_dp_if.slave   bus
);
  localparam int MuxWidth = $clog2(NumofSlave + 1);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  mux_state_e          state;
  logic [MuxWidth-1:0] dp_sel;
  logic [DWidth-1:0]   slave_rdata;
  logic                slave_resp;
  logic                slave_ready;
  logic [DWidth-1:0]   rdata;
  logic                resp;
  logic                ready;
  logic                addr_mapped;
  logic                enter_active;
  logic                timeout_expired;

  // Slot 0 inputs exist only to keep the port arrays uniform; the default
  // slave is implemented internally.
  logic unused_slot0;
  assign unused_slot0 = ^{bus.rdata_i[0], bus.resp_i[0], bus.readyout_i[0]};

  assign addr_mapped  = sel_is_mapped(32'(bus.mux_sel_i), NumofSlave);
  assign enter_active = ready && bus.trans_i && addr_mapped;

`ifdef BUS_MUX_TIMEOUT_EN
  logic stall;
  assign stall = (state == ACTIVE) && !slave_ready;

  bus_mux_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (enter_active),
    .stall_i   (stall),
    .expired_o (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // Pick the response of the slave selected for the current data phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    slave_rdata = '0;
    slave_resp  = RESP_OKAY;
    slave_ready = 1'b0;
    for (int i = 1; i <= NumofSlave; i++) begin
      if (dp_sel == MuxWidth'(i)) begin
        slave_rdata = bus.rdata_i[i];
        slave_resp  = bus.resp_i[i];
        slave_ready = bus.readyout_i[i];
      end
    end
  end

  // Master-facing response per data-phase state; ACTIVE passes the slave through.
  always_comb begin
    ready = 1'b1;
    resp  = RESP_OKAY;
    rdata = '0;
    unique case (state)
      IDLE: ;
      ACTIVE: begin
        ready = slave_ready;
        resp  = slave_resp;
        rdata = slave_rdata;
      end
      ERR1: begin
        ready = 1'b0;
        resp  = RESP_ERROR;
      end
      ERR2: resp = RESP_ERROR;
      default: ;
    endcase
  end

  // Data-phase FSM: accept an address phase whenever ready is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      dp_sel <= MuxWidth'(DEFAULT_SLAVE_IDX);
    end else if (state == ERR1) begin
      state <= ERR2;
    end else if (timeout_expired) begin
      state  <= ERR1;
      dp_sel <= MuxWidth'(DEFAULT_SLAVE_IDX);
    end else if (ready) begin
      if (!bus.trans_i) begin
        state  <= IDLE;
        dp_sel <= MuxWidth'(DEFAULT_SLAVE_IDX);
      end else if (addr_mapped) begin
        state  <= ACTIVE;
        dp_sel <= bus.mux_sel_i;
      end else begin
        state  <= ERR1;
        dp_sel <= MuxWidth'(DEFAULT_SLAVE_IDX);
      end
    end
  end

  assign bus.dp_sel_o = dp_sel;
  assign bus.rdata_o  = rdata;
  assign bus.resp_o   = resp;
  assign bus.ready_o  = ready;
endmodule

// File: tb/tb_bus_resp_mux_dp.sv
// Self-checking bench for bus_resp_mux_dp: directed scenarios plus a random
// transaction stream checked against a transfer-level model.
module tb_bus_resp_mux_dp;
  import bus_mux_pkg::*;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int MW = $clog2(NS + 1);

  typedef enum int {TX_IDLE, TX_UNMAPPED, TX_SLAVE} txn_kind_e;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  bus_resp_mux_dp_if #(.DWidth(DW), .NumofSlave(NS)) bus ();

  bus_resp_mux_dp #(
    .DWidth(DW),
    .NumofSlave(NS),
    .TimeoutCycles(4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  logic          exp_ready;
  logic          exp_resp;
  logic [DW-1:0] exp_rdata;
  logic [MW-1:0] exp_sel;
  bit            chk_sel;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Randomize every slave, idle the address phase, expect an IDLE OKAY beat.
  task automatic begin_cycle();
    for (int i = 0; i <= NS; i++) begin
      bus.rdata_i[i]    = $urandom;
      bus.resp_i[i]     = 1'($urandom_range(0, 1));
      bus.readyout_i[i] = 1'($urandom_range(0, 1));
    end
    bus.trans_i   = 1'b0;
    bus.mux_sel_i = '0;
    exp_ready = 1'b1;
    exp_resp  = 1'b0;
    exp_rdata = '0;
    exp_sel   = '0;
    chk_sel   = 1'b0;
  endtask

  task automatic test_reset();
    begin_cycle();
    rst_i         = 1'b1;
    bus.trans_i   = 1'b1;
    bus.mux_sel_i = MW'(2);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.rdata_o !== '0 || bus.dp_sel_o !== '0)
      $display("FAIL reset: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=1 resp=0 rdata=0 sel=0",
               bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o);
    else passes++;
    rst_i       = 1'b0;
    bus.trans_i = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    for (int c = 0; c < 3; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(2);
      end else if (c == 1) begin
        bus.rdata_i[2] = 32'hCAFE_0002; bus.resp_i[2] = 1'b0; bus.readyout_i[2] = 1'b1;
        exp_rdata = 32'hCAFE_0002; exp_sel = MW'(2); chk_sel = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL zero_wait c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  task automatic test_wait_states();
    for (int c = 0; c < 6; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(1);
      end else if (c <= 4) begin
        // Stall on slave 1 while a competing select for slave 3 is presented.
        bus.readyout_i[1] = (c == 4);
        bus.resp_i[1]     = 1'b0;
        bus.readyout_i[3] = 1'b1;
        if (c < 4) begin
          bus.trans_i = 1'b1; bus.mux_sel_i = MW'(3);
        end
        exp_ready = (c == 4);
        exp_rdata = bus.rdata_i[1];
        exp_sel   = MW'(1);
        chk_sel   = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL wait_states c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  task automatic test_unmapped(input logic [MW-1:0] sel);
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = sel;
      end else if (c <= 2) begin
        exp_ready = (c == 2);
        exp_resp  = 1'b1;
        chk_sel   = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL unmapped sel%0d c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 sel, c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(1);
      end else if (c == 1) begin
        bus.readyout_i[1] = 1'b1; bus.resp_i[1] = 1'b0;
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(3);
        exp_rdata = bus.rdata_i[1]; exp_sel = MW'(1); chk_sel = 1'b1;
      end else if (c == 2) begin
        bus.readyout_i[3] = 1'b1; bus.resp_i[3] = 1'b0;
        exp_rdata = bus.rdata_i[3]; exp_sel = MW'(3); chk_sel = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL back_to_back c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  task automatic test_slave_error();
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(4);
      end else if (c <= 2) begin
        bus.resp_i[4] = 1'b1; bus.readyout_i[4] = (c == 2);
        exp_ready = (c == 2); exp_resp = 1'b1;
        exp_rdata = bus.rdata_i[4]; exp_sel = MW'(4); chk_sel = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL slave_error c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  task automatic test_reset_abort();
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      rst_i = 1'b0;
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(1);
      end else if (c == 1) begin
        bus.readyout_i[1] = 1'b0;
        rst_i = 1'b1;
        exp_ready = 1'b0; exp_resp = bus.resp_i[1];
        exp_rdata = bus.rdata_i[1]; exp_sel = MW'(1); chk_sel = 1'b1;
      end else if (c == 2) begin
        bus.readyout_i[1] = 1'b0;
        chk_sel = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL reset_abort c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
    rst_i = 1'b0;
  endtask

`ifdef BUS_MUX_TIMEOUT_EN
  localparam int TO_STALLS = 4;
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_STALLS = 8;
  localparam int TO_CYCLES = 11;
`endif

  task automatic test_timeout();
    for (int c = 0; c < TO_CYCLES; c++) begin
      begin_cycle();
      if (c == 0) begin
        bus.trans_i = 1'b1; bus.mux_sel_i = MW'(2);
      end else if (c <= TO_STALLS) begin
        bus.readyout_i[2] = 1'b0;
        exp_ready = 1'b0; exp_resp = bus.resp_i[2];
        exp_rdata = bus.rdata_i[2]; exp_sel = MW'(2); chk_sel = 1'b1;
`ifdef BUS_MUX_TIMEOUT_EN
      end else if (c == TO_STALLS + 1) begin
        exp_ready = 1'b0; exp_resp = 1'b1;
      end else if (c == TO_STALLS + 2) begin
        exp_resp = 1'b1;
`else
      end else if (c == TO_STALLS + 1) begin
        bus.readyout_i[2] = 1'b1;
        exp_resp = bus.resp_i[2];
        exp_rdata = bus.rdata_i[2]; exp_sel = MW'(2); chk_sel = 1'b1;
`endif
      end
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
          (chk_sel && bus.dp_sel_o !== exp_sel))
        $display("FAIL timeout c%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                 c, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
      else passes++;
      step();
    end
  endtask

  // Random transfer stream. Each transfer's data phase is modelled as a list of
  // beats: idle = one OKAY beat, unmapped = ERROR not-ready then ERROR ready,
  // slave = waits stalled beats then one ready beat with the slave's response.
  // The next address phase is offered only on the final beat.
  task automatic test_random(input int num_txn);
    txn_kind_e     prev_kind = TX_IDLE;
    logic [MW-1:0] prev_sel  = '0;
    int            prev_wait = 0;
    txn_kind_e     next_kind;
    logic [MW-1:0] next_sel;
    int            next_wait;
    int            beats;
    int            pick;
    bit            last;
    for (int t = 0; t <= num_txn; t++) begin
      next_wait = 0;
      next_sel  = MW'($urandom_range(0, (1 << MW) - 1));
      pick      = (t == num_txn) ? 0 : int'($urandom_range(0, 9));
      if (pick < 2) begin
        next_kind = TX_IDLE;
      end else if (pick < 4) begin
        next_kind = TX_UNMAPPED;
        next_sel  = MW'($urandom_range(NS + 1, (1 << MW) - 1));
        if ($urandom_range(0, 1) == 0) next_sel = '0;
      end else begin
        next_kind = TX_SLAVE;
        next_sel  = MW'($urandom_range(1, NS));
        next_wait = int'($urandom_range(0, 3));
      end
      beats = (prev_kind == TX_IDLE) ? 1 : (prev_kind == TX_UNMAPPED) ? 2 : prev_wait + 1;
      for (int b = 0; b < beats; b++) begin
        begin_cycle();
        last = (b == beats - 1);
        if (last) begin
          bus.trans_i   = (next_kind != TX_IDLE);
          bus.mux_sel_i = next_sel;
        end else begin
          bus.trans_i   = 1'($urandom_range(0, 1));
          bus.mux_sel_i = MW'($urandom_range(0, (1 << MW) - 1));
        end
        if (prev_kind == TX_UNMAPPED) begin
          exp_ready = last; exp_resp = 1'b1; chk_sel = 1'b1;
        end else if (prev_kind == TX_SLAVE) begin
          bus.readyout_i[prev_sel] = last;
          exp_ready = last;
          exp_resp  = bus.resp_i[prev_sel];
          exp_rdata = bus.rdata_i[prev_sel];
          exp_sel   = prev_sel;
          chk_sel   = 1'b1;
        end
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== exp_ready || bus.resp_o !== exp_resp || bus.rdata_o !== exp_rdata ||
            (chk_sel && bus.dp_sel_o !== exp_sel))
          $display("FAIL random t%0d b%0d: got rdy=%b resp=%b rdata=%h sel=%0d exp rdy=%b resp=%b rdata=%h sel=%0d",
                   t, b, bus.ready_o, bus.resp_o, bus.rdata_o, bus.dp_sel_o, exp_ready, exp_resp, exp_rdata, exp_sel);
        else passes++;
        step();
      end
      prev_kind = next_kind;
      prev_sel  = next_sel;
      prev_wait = next_wait;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_unmapped(MW'(0));
    test_unmapped(MW'(5));
    test_unmapped(MW'(7));
    test_back_to_back();
    test_slave_error();
    test_reset_abort();
    test_timeout();
    test_random(80);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
